// File: rtl/fft16_top.sv
// rtl/fft16_top.sv - streaming 16-point radix-2 DIT FFT, output scaled by 1/16
module fft16_top (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_push,
  input  logic [15:0] in_real,
  input  logic [15:0] in_imag,
  output logic        in_stall,
  output logic        out_push_F,
  output logic [15:0] out_real_F,
  output logic [15:0] out_imag_F,
  input  logic        out_stall
);

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  smp_q, smp_d;
  logic [4:0]  bfly_q, bfly_d;
  logic [3:0]  rd_q, rd_d;
  logic        push_q, push_d;
  logic [15:0] ore_q, ore_d;
  logic [15:0] oim_q, oim_d;

  logic [15:0] buf_re [16];
  logic [15:0] buf_im [16];

  logic [3:0]  addr_a, addr_b;
  logic [2:0]  tw_k;
  logic signed [15:0] a_re, a_im, b_re, b_im;
  logic signed [15:0] w_re, w_im;
  logic signed [31:0] m_re, m_im;
  logic signed [16:0] t_re, t_im;
  logic signed [16:0] s_re, s_im, d_re, d_im;
  logic [15:0] na_re, na_im, nb_re, nb_im;

  // Samples land in bit-reversed order so the DIT stages run in place.
  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  // Butterfly pair addresses and twiddle index from stage (bfly_q[4:3]) and butterfly j.
  always_comb begin
    addr_a = 4'd0;
    addr_b = 4'd0;
    tw_k   = 3'd0;
    case (bfly_q[4:3])
      2'd0: begin
        addr_a = {bfly_q[2:0], 1'b0};
        addr_b = {bfly_q[2:0], 1'b1};
        tw_k   = 3'd0;
      end
      2'd1: begin
        addr_a = {bfly_q[2:1], 1'b0, bfly_q[0]};
        addr_b = {bfly_q[2:1], 1'b1, bfly_q[0]};
        tw_k   = {bfly_q[0], 2'b00};
      end
      2'd2: begin
        addr_a = {bfly_q[2], 1'b0, bfly_q[1:0]};
        addr_b = {bfly_q[2], 1'b1, bfly_q[1:0]};
        tw_k   = {bfly_q[1:0], 1'b0};
      end
      default: begin
        addr_a = {1'b0, bfly_q[2:0]};
        addr_b = {1'b1, bfly_q[2:0]};
        tw_k   = bfly_q[2:0];
      end
    endcase
  end

  // Q1.15 twiddle ROM: W16^k = cos - j*sin.
  always_comb begin
    w_re = 16'sd32767;
    w_im = 16'sd0;
    case (tw_k)
      3'd0: begin w_re =  16'sd32767; w_im =  16'sd0;     end
      3'd1: begin w_re =  16'sd30274; w_im = -16'sd12540; end
      3'd2: begin w_re =  16'sd23170; w_im = -16'sd23170; end
      3'd3: begin w_re =  16'sd12540; w_im = -16'sd30274; end
      3'd4: begin w_re =  16'sd0;     w_im = -16'sd32767; end
      3'd5: begin w_re = -16'sd12540; w_im = -16'sd30274; end
      3'd6: begin w_re = -16'sd23170; w_im = -16'sd23170; end
      default: begin w_re = -16'sd30274; w_im = -16'sd12540; end
    endcase
  end

  assign a_re = buf_re[addr_a];
  assign a_im = buf_im[addr_a];
  assign b_re = buf_re[addr_b];
  assign b_im = buf_im[addr_b];

  assign m_re = b_re * w_re - b_im * w_im;
  assign m_im = b_re * w_im + b_im * w_re;

  // k=0 and k=4 are exact rotations, so they skip the truncating multiplier.
  always_comb begin
    t_re = 17'(m_re >>> 15);
    t_im = 17'(m_im >>> 15);
    if (tw_k == 3'd0) begin
      t_re = {b_re[15], b_re};
      t_im = {b_im[15], b_im};
    end else if (tw_k == 3'd4) begin
      t_re = {b_im[15], b_im};
      t_im = -{b_re[15], b_re};
    end
  end

  assign s_re  = {a_re[15], a_re} + t_re;
  assign s_im  = {a_im[15], a_im} + t_im;
  assign d_re  = {a_re[15], a_re} - t_re;
  assign d_im  = {a_im[15], a_im} - t_im;
  assign na_re = 16'(s_re >>> 1);
  assign na_im = 16'(s_im >>> 1);
  assign nb_re = 16'(d_re >>> 1);
  assign nb_im = 16'(d_im >>> 1);

  // Sample buffer: written by the loader in LOAD and by the butterfly in COMPUTE.
  always_ff @(posedge clk) begin
    if (state_q == LOAD && in_push) begin
      buf_re[bitrev4(smp_q)] <= in_real;
      buf_im[bitrev4(smp_q)] <= in_imag;
    end else if (state_q == COMPUTE) begin
      buf_re[addr_a] <= na_re;
      buf_im[addr_a] <= na_im;
      buf_re[addr_b] <= nb_re;
      buf_im[addr_b] <= nb_im;
    end
  end

  // Next-state logic: load 16 samples, run 32 butterflies, stream 16 bins.
  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    bfly_d  = bfly_q;
    rd_d    = rd_q;
    push_d  = push_q;
    ore_d   = ore_q;
    oim_d   = oim_q;
    case (state_q)
      LOAD: begin
        if (in_push) begin
          smp_d = smp_q + 4'd1;
          if (smp_q == 4'd15) begin
            state_d = COMPUTE;
            bfly_d  = 5'd0;
          end
        end
      end
      COMPUTE: begin
        bfly_d = bfly_q + 5'd1;
        if (bfly_q == 5'd31) begin
          state_d = OUTPUT;
          rd_d    = 4'd0;
        end
      end
      OUTPUT: begin
        if (!push_q) begin
          push_d = 1'b1;
          ore_d  = buf_re[rd_q];
          oim_d  = buf_im[rd_q];
        end else if (!out_stall) begin
          if (rd_q == 4'd15) begin
            push_d  = 1'b0;
            rd_d    = 4'd0;
            state_d = LOAD;
          end else begin
            rd_d  = rd_q + 4'd1;
            ore_d = buf_re[rd_q + 4'd1];
            oim_d = buf_im[rd_q + 4'd1];
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Control and output registers; reset discards any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
      smp_q   <= 4'd0;
      bfly_q  <= 5'd0;
      rd_q    <= 4'd0;
      push_q  <= 1'b0;
      ore_q   <= 16'd0;
      oim_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      bfly_q  <= bfly_d;
      rd_q    <= rd_d;
      push_q  <= push_d;
      ore_q   <= ore_d;
      oim_q   <= oim_d;
    end
  end

  assign in_stall   = (state_q != LOAD);
  assign out_push_F = push_q;
  assign out_real_F = ore_q;
  assign out_imag_F = oim_q;

endmodule

// File: tb/tb_fft16_top.sv
// tb/tb_fft16_top.sv - randomized self-checking bench for fft16_top against a DFT model
module tb_fft16_top;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_push = 1'b0;
  logic [15:0] in_real = 16'd0;
  logic [15:0] in_imag = 16'd0;
  logic        in_stall;
  logic        out_push_F;
  logic [15:0] out_real_F;
  logic [15:0] out_imag_F;
  logic        out_stall = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int xr [16];
  int xi [16];
  real PI = 3.14159265358979;

  fft16_top dut (
    .clk        (clk),
    .reset      (reset),
    .in_push    (in_push),
    .in_real    (in_real),
    .in_imag    (in_imag),
    .in_stall   (in_stall),
    .out_push_F (out_push_F),
    .out_real_F (out_real_F),
    .out_imag_F (out_imag_F),
    .out_stall  (out_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp, input int tol);
    n_checks++;
    if (got > exp + tol || got < exp - tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else return -$rtoi(0.5 - v);
  endfunction

  // Reference: X[k]/16 with X[k] = sum x[n] * exp(-j*2*pi*k*n/16).
  task automatic ref_bin(input int k, output int er, output int ei);
    real sr, si, th;
    sr = 0.0;
    si = 0.0;
    for (int n = 0; n < 16; n++) begin
      th = 2.0 * PI * k * n / 16.0;
      sr += xr[n] * $cos(th) + xi[n] * $sin(th);
      si += xi[n] * $cos(th) - xr[n] * $sin(th);
    end
    er = rnd(sr / 16.0);
    ei = rnd(si / 16.0);
  endtask

  task automatic send_frame(input bit gaps);
    for (int n = 0; n < 16; n++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          in_push = 1'b0;
        end
      end
      @(negedge clk);
      if (n == 0) check("load_ready", int'(in_stall), 0, 0);
      in_push = 1'b1;
      in_real = 16'(xr[n]);
      in_imag = 16'(xi[n]);
    end
  endtask

  // mode 0: no backpressure, 1: fixed stall pattern, 2: random stall
  task automatic collect(input int mode, input int tol, input bit junk, input string name);
    int  c, nx, first, st2, er, ei, prev_re, prev_im;
    bit  prev_stall, done;
    int  got_re [16];
    int  got_im [16];
    c = 0; nx = 0; first = 0; st2 = 0; prev_re = 0; prev_im = 0;
    prev_stall = 1'b0; done = 1'b0;
    for (int k = 0; k < 16; k++) begin
      got_re[k] = -99999;
      got_im[k] = -99999;
    end
    while (!done && c < 400) begin
      @(negedge clk);
      c++;
      in_push = junk && (c < 30);
      in_real = 16'd7;
      in_imag = 16'd7;
      if (c == 1) check({name, " stall_rise"}, int'(in_stall), 1, 0);
      case (mode)
        0: out_stall = 1'b0;
        1: begin
          out_stall = (c >= 31 && c <= 35);
          if (nx == 6 && st2 < 2) begin
            out_stall = 1'b1;
            st2++;
          end
        end
        default: out_stall = ($urandom_range(0, 3) == 0);
      endcase
      if (prev_stall) begin
        check({name, " hold_push"}, int'(out_push_F), 1, 0);
        check({name, " hold_re"}, int'($signed(out_real_F)), prev_re, 0);
        check({name, " hold_im"}, int'($signed(out_imag_F)), prev_im, 0);
      end
      if (mode == 0 && nx > 0) check({name, " gapless"}, int'(out_push_F), 1, 0);
      if (out_push_F) begin
        if (first == 0) begin
          first = c;
          check({name, " latency"}, c, 34, 0);
          check({name, " busy"}, int'(in_stall), 1, 0);
        end
        if (!out_stall) begin
          got_re[nx] = int'($signed(out_real_F));
          got_im[nx] = int'($signed(out_imag_F));
          nx++;
          if (nx == 16) done = 1'b1;
        end
        prev_stall = out_stall;
        prev_re    = int'($signed(out_real_F));
        prev_im    = int'($signed(out_imag_F));
      end else begin
        prev_stall = 1'b0;
      end
    end
    if (!done) check({name, " timeout_bins"}, nx, 16, 0);
    in_push   = 1'b0;
    out_stall = 1'b0;
    @(negedge clk);
    check({name, " end_push"}, int'(out_push_F), 0, 0);
    check({name, " end_stall"}, int'(in_stall), 0, 0);
    for (int k = 0; k < 16; k++) begin
      ref_bin(k, er, ei);
      check($sformatf("%s bin%0d re", name, k), got_re[k], er, tol);
      check($sformatf("%s bin%0d im", name, k), got_im[k], ei, tol);
    end
  endtask

  task automatic set_impulse();
    for (int n = 0; n < 16; n++) begin
      xr[n] = (n == 0) ? 16384 : 0;
      xi[n] = 0;
    end
  endtask

  task automatic set_dc();
    for (int n = 0; n < 16; n++) begin
      xr[n] = 1600;
      xi[n] = 0;
    end
  endtask

  task automatic set_nyquist();
    for (int n = 0; n < 16; n++) begin
      xr[n] = (n % 2 == 0) ? 1600 : -1600;
      xi[n] = 0;
    end
  endtask

  task automatic set_random();
    for (int n = 0; n < 16; n++) begin
      xr[n] = int'($urandom_range(0, 32767)) - 16384;
      xi[n] = int'($urandom_range(0, 32767)) - 16384;
    end
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst push", int'(out_push_F), 0, 0);
    check("rst re", int'(out_real_F), 0, 0);
    check("rst im", int'(out_imag_F), 0, 0);
    check("rst stall", int'(in_stall), 0, 0);
    @(negedge clk);
    reset = 1'b1;

    set_impulse(); send_frame(1'b0); collect(0, 0, 1'b0, "impulse");
    set_dc();      send_frame(1'b0); collect(0, 0, 1'b0, "dc");
    set_nyquist(); send_frame(1'b0); collect(0, 2, 1'b0, "nyquist");
    set_impulse(); send_frame(1'b0); collect(1, 0, 1'b0, "backpr");
    set_impulse(); send_frame(1'b0); collect(0, 0, 1'b1, "junk");
    set_dc();      send_frame(1'b0); collect(0, 0, 1'b0, "dc_after_junk");

    set_random(); send_frame(1'b0);
    @(negedge clk);
    in_push = 1'b0;
    repeat (9) @(negedge clk);
    check("mid busy", int'(in_stall), 1, 0);
    reset = 1'b0;
    #1;
    check("mid rst push", int'(out_push_F), 0, 0);
    check("mid rst stall", int'(in_stall), 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    set_impulse(); send_frame(1'b0); collect(0, 0, 1'b0, "after_rst");

    for (int f = 0; f < 6; f++) begin
      set_random();
      send_frame(1'b1);
      collect(2, 8, 1'b0, $sformatf("rand%0d", f));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
